// File: rtl/vg_flow_ctrl_if.sv
// Control/fetch/decode handshake bundle between the vector-generator flow controller
// and its surroundings (DMA control, vector memory read port, opcode sequencer).
interface vg_flow_ctrl_if #(
  parameter int ADDR_W = 13
);
  // Handshakes: fetch_req is held high (fetch_addr stable) until the cycle fetch_ack
  // is sampled high on a rising edge; dmago, stop and op_valid are single-cycle
  // strobes sampled on the rising edge, with op/target valid only alongside op_valid.
  logic              dmago;
  logic              stop;
  logic              fetch_ack;
  logic              op_valid;
  logic [3:0]        op;
  logic [ADDR_W-1:0] target;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              running;
  logic              halted;
  logic              stack_err;
  logic [2:0]        depth;
  logic [1:0]        state_dbg;

  modport master (
    output dmago, stop, fetch_ack, op_valid, op, target,
    input  fetch_req, fetch_addr, running, halted, stack_err, depth, state_dbg
  );

  modport slave (
    input  dmago, stop, fetch_ack, op_valid, op, target,
    output fetch_req, fetch_addr, running, halted, stack_err, depth, state_dbg
  );
endinterface

// File: rtl/vg_flow_ctrl.sv
// Vector-generator program-flow controller: PC, return stack, fetch requests and
// PC advance from each decoded opcode.
module vg_flow_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  vg_flow_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_WAIT_OP = 2'd2
  } state_e;

  localparam logic [3:0] OP_LABS = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_JSRL = 4'hC;
  localparam logic [3:0] OP_RTSL = 4'hD;
  localparam logic [3:0] OP_JMPL = 4'hE;
  localparam logic [3:0] OP_SVEC = 4'hF;

  localparam int         IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] SP_FULL = 3'(STACK_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        sp_q, sp_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push_en;
  logic [ADDR_W-1:0] ret_addr;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign ret_addr = pc_q + ADDR_W'(1);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - 3'd1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    halted_d = halted_q;
    err_d    = err_q;
    push_en  = 1'b0;

    if (bus.stop) begin
      state_d = S_IDLE;
    end else if (bus.dmago) begin
      state_d  = S_FETCH;
      pc_d     = '0;
      sp_d     = '0;
      halted_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_FETCH: begin
          if (bus.fetch_ack) state_d = S_WAIT_OP;
        end
        S_WAIT_OP: begin
          if (bus.op_valid) begin
            state_d = S_FETCH;
            case (bus.op)
              OP_SVEC: pc_d = pc_q + ADDR_W'(1);
              OP_JMPL: pc_d = bus.target;
              OP_JSRL: begin
                // Overflow is terminal: PC and SP stay put so the fault address is visible.
                if (sp_q == SP_FULL) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + 3'd1;
                  pc_d    = bus.target;
                end
              end
              OP_RTSL: begin
                if (sp_q == 3'd0) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end else begin
                  sp_d = sp_q - 3'd1;
                  pc_d = stack_q[pop_idx];
                end
              end
              OP_HALT: begin
                halted_d = 1'b1;
                state_d  = S_IDLE;
              end
              // VCTR (0x0-0x9) and LABS are both two-word instructions.
              default: pc_d = pc_q + ADDR_W'(2);
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  // Return-stack storage survives dmago; only the pointer is rewound.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push_en) begin
      stack_q[push_idx] <= ret_addr;
    end
  end

  assign bus.fetch_req  = (state_q == S_FETCH);
  assign bus.fetch_addr = pc_q;
  assign bus.running    = (state_q != S_IDLE);
  assign bus.halted     = halted_q;
  assign bus.stack_err  = err_q;
  assign bus.depth      = sp_q;
  assign bus.state_dbg  = state_q;

endmodule
